// File: rtl/eth_tx_pkt_gen.sv
// Burst packet generator driving the eth_tx application TX interface with a byte-ramp payload.
// Optional per-packet cancel beat is enabled by defining ETH_TX_PKT_GEN_CANCEL_EN.
module eth_tx_pkt_gen #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned KEEP_W         = DATA_W / 8,
  parameter int unsigned LEN_W          = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W      = 16,
  parameter int unsigned BLOCK_N        = 8,
  parameter int unsigned BLOCK_LEN_W    = $clog2(BLOCK_N + 1),
  parameter int unsigned APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1)
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      cfg_start_i,
  input  logic [PKT_LEN_W-1:0]      cfg_pkt_len_i,
  input  logic [PKT_LEN_W-1:0]      cfg_pkt_cnt_i,
  input  logic [7:0]                cfg_gap_i,
`ifdef ETH_TX_PKT_GEN_CANCEL_EN
  input  logic [PKT_LEN_W-1:0]      cfg_cancel_beat_i,
  input  logic                      cfg_cancel_en_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  output logic [PKT_LEN_W-1:0]      pkt_sent_cnt_o,
  output logic                      app_early_v_o,
  input  logic                      app_ready_v_i,
  output logic                      app_cancel_o,
  output logic [DATA_W-1:0]         app_data_o,
  output logic [LEN_W-1:0]          app_len_o,
  output logic [PKT_LEN_W-1:0]      app_pkt_len_o,
  output logic [15:0]               app_cs_o,
  output logic                      app_last_o,
  output logic                      app_last_block_next_o,
  output logic [APP_LAST_LEN_W-1:0] app_last_block_next_len_o
);

  localparam int unsigned KEEP_SH = $clog2(KEEP_W);

  typedef enum logic [2:0] {StIdle, StHead, StData, StLast, StGap} state_e;

  state_e                   state_q, state_d;
  logic [PKT_LEN_W-1:0]     len_q, len_d, cnt_q, cnt_d, sent_q, sent_d, beat_q, beat_d;
  logic [PKT_LEN_W-1:0]     last_off_q, last_off_d;
  logic [BLOCK_LEN_W-1:0]   last_blk_len_q, last_blk_len_d;
  logic [7:0]               gap_q, gap_d, gcnt_q, gcnt_d;
  logic                     start_ok, end_pkt, cancel_hit;
  logic [PKT_LEN_W-1:0]     nb;

  logic                     busy_q, busy_d, done_q, done_d, early_q, early_d;
  logic                     last_q, last_d, lbn_q, lbn_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [LEN_W-1:0]         alen_q, alen_d;
  logic [PKT_LEN_W-1:0]     plen_q, plen_d;
  logic [APP_LAST_LEN_W-1:0] lbn_len_q, lbn_len_d;
  logic [PKT_LEN_W-1:0]     off;
  logic [7:0]               base;
  logic [LEN_W-1:0]         rem_d;

  assign start_ok = (state_q == StIdle) && cfg_start_i &&
                    (cfg_pkt_len_i != '0) && (cfg_pkt_cnt_i != '0);
  assign nb = len_q >> KEEP_SH;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    sent_d         = sent_q;
    beat_d         = beat_q;
    gcnt_d         = gcnt_q;
    last_off_d     = last_off_q;
    last_blk_len_d = last_blk_len_q;
    done_d         = 1'b0;
    end_pkt        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          len_d          = cfg_pkt_len_i;
          cnt_d          = cfg_pkt_cnt_i;
          gap_d          = cfg_gap_i;
          sent_d         = '0;
          // Byte offset of the final PHY block, where last_block_next fires.
          last_off_d     = cfg_pkt_len_i - PKT_LEN_W'(cfg_pkt_len_i % BLOCK_N);
          last_blk_len_d = BLOCK_LEN_W'(cfg_pkt_len_i % BLOCK_N);
          state_d        = StHead;
        end
      end
      StHead: begin
        if (app_ready_v_i) begin
          beat_d  = '0;
          state_d = (nb != '0) ? StData : StLast;
        end
      end
      StData: begin
        if (cancel_hit) begin
          end_pkt = 1'b1;
        end else if (beat_q == nb - PKT_LEN_W'(1)) begin
          state_d = StLast;
        end else begin
          beat_d = beat_q + PKT_LEN_W'(1);
        end
      end
      StLast: end_pkt = 1'b1;
      StGap: begin
        if (gcnt_q <= 8'd1) state_d = StHead;
        else gcnt_d = gcnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
    if (end_pkt) begin
      sent_d = sent_q + PKT_LEN_W'(1);
      if (sent_d == cnt_q) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else if (gap_q != 8'd0) begin
        state_d = StGap;
        gcnt_d  = gap_q;
      end else begin
        state_d = StHead;
      end
    end
  end

  // Outputs are derived from the next state so they can be registered alongside it.
  always_comb begin
    busy_d    = (state_d != StIdle);
    early_d   = 1'b0;
    last_d    = 1'b0;
    lbn_d     = 1'b0;
    lbn_len_d = '0;
    alen_d    = '0;
    plen_d    = '0;
    data_d    = '0;
    off       = '0;
    base      = '0;
    rem_d     = LEN_W'(len_d % KEEP_W);
    case (state_d)
      StHead: begin
        early_d = 1'b1;
        plen_d  = len_d;
      end
      StData: begin
        off    = beat_d << KEEP_SH;
        base   = 8'(sent_d + off);
        plen_d = len_d;
        alen_d = LEN_W'(KEEP_W);
        for (int unsigned j = 0; j < KEEP_W; j++) data_d[j*8 +: 8] = base + 8'(j);
        if (off == last_off_d) begin
          lbn_d     = 1'b1;
          lbn_len_d = APP_LAST_LEN_W'(last_blk_len_d);
        end
      end
      StLast: begin
        off    = (len_d >> KEEP_SH) << KEEP_SH;
        base   = 8'(sent_d + off);
        plen_d = len_d;
        alen_d = rem_d;
        last_d = 1'b1;
        for (int unsigned j = 0; j < KEEP_W; j++) begin
          if (j < 32'(rem_d)) data_d[j*8 +: 8] = base + 8'(j);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q        <= StIdle;
      len_q          <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      sent_q         <= '0;
      beat_q         <= '0;
      gcnt_q         <= '0;
      last_off_q     <= '0;
      last_blk_len_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      early_q        <= 1'b0;
      last_q         <= 1'b0;
      lbn_q          <= 1'b0;
      lbn_len_q      <= '0;
      alen_q         <= '0;
      plen_q         <= '0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      sent_q         <= sent_d;
      beat_q         <= beat_d;
      gcnt_q         <= gcnt_d;
      last_off_q     <= last_off_d;
      last_blk_len_q <= last_blk_len_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      early_q        <= early_d;
      last_q         <= last_d;
      lbn_q          <= lbn_d;
      lbn_len_q      <= lbn_len_d;
      alen_q         <= alen_d;
      plen_q         <= plen_d;
      data_q         <= data_d;
    end
  end

`ifdef ETH_TX_PKT_GEN_CANCEL_EN
  logic                 cancel_en_q, cancel_en_d, cancel_q, cancel_d;
  logic [PKT_LEN_W-1:0] cancel_beat_q, cancel_beat_d;

  always_comb begin
    cancel_en_d   = cancel_en_q;
    cancel_beat_d = cancel_beat_q;
    if (start_ok) begin
      cancel_en_d   = cfg_cancel_en_i;
      cancel_beat_d = cfg_cancel_beat_i;
    end
  end

  // A matching beat index only exists while beat < NB, so no explicit range check is needed.
  assign cancel_hit = (state_q == StData) && cancel_en_q && (beat_q == cancel_beat_q);
  assign cancel_d   = (state_d == StData) && cancel_en_d && (beat_d == cancel_beat_d);

  always_ff @(posedge clk) begin
    if (nreset) begin
      cancel_en_q   <= 1'b0;
      cancel_beat_q <= '0;
      cancel_q      <= 1'b0;
    end else begin
      cancel_en_q   <= cancel_en_d;
      cancel_beat_q <= cancel_beat_d;
      cancel_q      <= cancel_d;
    end
  end

  assign app_cancel_o = cancel_q;
`else
  assign cancel_hit   = 1'b0;
  assign app_cancel_o = 1'b0;
`endif

  assign busy_o                    = busy_q;
  assign done_o                    = done_q;
  assign pkt_sent_cnt_o            = sent_q;
  assign app_early_v_o             = early_q;
  assign app_data_o                = data_q;
  assign app_len_o                 = alen_q;
  assign app_pkt_len_o             = plen_q;
  assign app_cs_o                  = 16'h0000;
  assign app_last_o                = last_q;
  assign app_last_block_next_o     = lbn_q;
  assign app_last_block_next_len_o = lbn_len_q;

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// Self-checking bench for eth_tx_pkt_gen: packet-level reference model compared every cycle,
// plus directed scenarios pinned with hand-computed values.
module tb_eth_tx_pkt_gen;

`ifdef ETH_TX_PKT_GEN_CANCEL_EN
  localparam bit CANCEL_ON = 1'b1;
`else
  localparam bit CANCEL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset, start, cancel_en;
  logic [15:0] plen, pcnt, cancel_beat;
  logic [7:0]  gap;
  logic        ready = 1'b0;
  logic        ready_rand, ready_man;

  logic        busy_o, done_o, app_early_v_o, app_cancel_o, app_last_o, app_lbn_o;
  logic [15:0] pkt_sent_cnt_o, app_data_o, app_pkt_len_o, app_cs_o;
  logic [1:0]  app_len_o;
  logic [3:0]  app_lbn_len_o;

  always #5 clk = ~clk;

  eth_tx_pkt_gen dut (
    .clk                       (clk),
    .nreset                    (nreset),
    .cfg_start_i               (start),
    .cfg_pkt_len_i             (plen),
    .cfg_pkt_cnt_i             (pcnt),
    .cfg_gap_i                 (gap),
`ifdef ETH_TX_PKT_GEN_CANCEL_EN
    .cfg_cancel_beat_i         (cancel_beat),
    .cfg_cancel_en_i           (cancel_en),
`endif
    .busy_o                    (busy_o),
    .done_o                    (done_o),
    .pkt_sent_cnt_o            (pkt_sent_cnt_o),
    .app_early_v_o             (app_early_v_o),
    .app_ready_v_i             (ready),
    .app_cancel_o              (app_cancel_o),
    .app_data_o                (app_data_o),
    .app_len_o                 (app_len_o),
    .app_pkt_len_o             (app_pkt_len_o),
    .app_cs_o                  (app_cs_o),
    .app_last_o                (app_last_o),
    .app_last_block_next_o     (app_lbn_o),
    .app_last_block_next_len_o (app_lbn_len_o)
  );

  typedef struct packed {
    logic        busy, done, early, cancel, last, lbn;
    logic [15:0] sent, pkt_len, data, cs;
    logic [1:0]  len;
    logic [3:0]  lbn_len;
  } rec_t;

  function automatic rec_t dut_rec();
    rec_t r;
    r.busy = busy_o;  r.done = done_o;  r.early = app_early_v_o;  r.cancel = app_cancel_o;
    r.last = app_last_o;  r.lbn = app_lbn_o;  r.sent = pkt_sent_cnt_o;
    r.pkt_len = app_pkt_len_o;  r.data = app_data_o;  r.cs = app_cs_o;
    r.len = app_len_o;  r.lbn_len = app_lbn_len_o;
    return r;
  endfunction

  // Ready driver: random or manual, updated once per cycle well clear of the edge.
  always begin
    @(posedge clk);
    #2;
    ready = ready_rand ? ($urandom_range(0, 2) == 0) : ready_man;
  end

  // ---------------- reference model: schedules whole packets as cycle records ----------------
  typedef enum int {MIdle, MHead, MQ} mmode_t;
  mmode_t      m_mode;
  logic [15:0] m_L, m_N, m_sent, m_cb;
  logic [7:0]  m_G;
  logic        m_ce;
  rec_t        sched[$];
  rec_t        expv;
  bit          exp_valid = 1'b0;

  function automatic rec_t blank_rec(logic [15:0] s, logic b);
    rec_t r;
    r = '0;
    r.sent = s;
    r.busy = b;
    return r;
  endfunction

  function automatic rec_t head_rec();
    rec_t r;
    r = blank_rec(m_sent, 1'b1);
    r.early = 1'b1;
    r.pkt_len = m_L;
    return r;
  endfunction

  function automatic void build_pkt();
    int nb, rr, p, last_i, off;
    bit cut;
    rec_t x;
    nb = int'(m_L) / 2;
    rr = int'(m_L) % 2;
    p = int'(m_sent);
    cut = CANCEL_ON && m_ce && (int'(m_cb) < nb);
    last_i = cut ? int'(m_cb) : nb - 1;
    for (int i = 0; i <= last_i; i++) begin
      off = 2 * i;
      x = blank_rec(m_sent, 1'b1);
      x.pkt_len = m_L;
      x.len = 2'd2;
      x.data = {8'(p + off + 1), 8'(p + off)};
      if ((off % 8 == 0) && (off / 8 == int'(m_L) / 8)) begin
        x.lbn = 1'b1;
        x.lbn_len = 4'(int'(m_L) % 8);
      end
      x.cancel = cut && (i == last_i);
      sched.push_back(x);
    end
    if (!cut) begin
      off = 2 * nb;
      x = blank_rec(m_sent, 1'b1);
      x.pkt_len = m_L;
      x.last = 1'b1;
      x.len = 2'(rr);
      x.data = {8'h00, (rr > 0) ? 8'(p + off) : 8'h00};
      sched.push_back(x);
    end
    m_sent = m_sent + 16'd1;
    if (m_sent != m_N) for (int g = 0; g < int'(m_G); g++) sched.push_back(blank_rec(m_sent, 1'b1));
  endfunction

  always @(posedge clk) begin
    rec_t nx;
    if (nreset) begin
      m_mode = MIdle;
      m_sent = '0;
      sched.delete();
      nx = blank_rec(16'd0, 1'b0);
    end else begin
      case (m_mode)
        MIdle: begin
          nx = blank_rec(m_sent, 1'b0);
          if (start && plen != 0 && pcnt != 0) begin
            m_L = plen;  m_N = pcnt;  m_G = gap;  m_cb = cancel_beat;  m_ce = cancel_en;
            m_sent = '0;
            nx = head_rec();
            m_mode = MHead;
          end
        end
        MHead: begin
          if (ready) begin
            build_pkt();
            nx = sched.pop_front();
            m_mode = MQ;
          end else begin
            nx = head_rec();
          end
        end
        default: begin
          if (sched.size() != 0) begin
            nx = sched.pop_front();
          end else if (m_sent == m_N) begin
            nx = blank_rec(m_sent, 1'b0);
            nx.done = 1'b1;
            m_mode = MIdle;
          end else begin
            nx = head_rec();
            m_mode = MHead;
          end
        end
      endcase
    end
    expv = nx;
    exp_valid = 1'b1;
  end

  // ---------------- single compare process: per-cycle model check + queued literal checks -----
  int          n_checks = 0;
  int          n_fail = 0;
  string       lit_nm[$];
  logic [31:0] lit_act[$], lit_exp[$];
  int          lit_rd = 0;

  always @(negedge clk) begin
    rec_t act;
    if (exp_valid) begin
      act = dut_rec();
      n_checks++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got %h expected %h", $time, act, expv);
      end
    end
    while (lit_rd < lit_nm.size()) begin
      n_checks++;
      if (lit_act[lit_rd] !== lit_exp[lit_rd]) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", lit_nm[lit_rd], lit_act[lit_rd],
                 lit_exp[lit_rd]);
      end
      lit_rd++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    lit_nm.push_back(nm);
    lit_act.push_back(act);
    lit_exp.push_back(ex);
  endtask

  // ---------------- monitor: beat log and event counters ----------------
  rec_t beat_log[$];
  int   done_cnt = 0, early_cnt = 0, gap_run = 0, gap_seen = -1;
  bit   in_gap = 1'b0;

  always @(negedge clk) begin
    if (app_len_o != 0 || app_last_o) beat_log.push_back(dut_rec());
    if (done_o) done_cnt++;
    if (app_early_v_o) early_cnt++;
    if (app_last_o) begin
      in_gap = 1'b1;
      gap_run = 0;
    end else if (in_gap) begin
      if (app_early_v_o) begin
        gap_seen = gap_run;
        in_gap = 1'b0;
      end else begin
        gap_run++;
      end
    end
  end

  task automatic start_burst(input logic [15:0] l, input logic [15:0] n, input logic [7:0] g);
    @(posedge clk);
    #1;
    plen = l;  pcnt = n;  gap = g;  start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy_o) chk("idle_timeout", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lb, db, eb, cnt;
    bit found;
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lb, db, eb, cnt;
    bit found;
    nreset = 1'b1;  start = 1'b0;  plen = '0;  pcnt = '0;  gap = '0;
    cancel_beat = '0;  cancel_en = 1'b0;  ready_rand = 1'b0;  ready_man = 1'b0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_sent", {16'd0, pkt_sent_cnt_o}, 32'd0);

    // Zero length / zero count starts are ignored.
    start_burst(16'd0, 16'd1, 8'd0);
    @(negedge clk);
    chk("zero_len_ignored", {31'd0, busy_o}, 32'd0);
    start_burst(16'd4, 16'd0, 8'd0);
    @(negedge clk);
    chk("zero_cnt_ignored", {31'd0, busy_o}, 32'd0);

    // Block-boundary packet, ready after 3 head cycles.
    lb = beat_log.size();  db = done_cnt;  eb = early_cnt;
    start_burst(16'd20, 16'd1, 8'd0);
    repeat (2) @(posedge clk);
    #1 ready_man = 1'b1;
    wait_idle(200);
    ready_man = 1'b0;
    chk("s1_beats", beat_log.size() - lb, 32'd11);
    chk("s1_head_cycles", early_cnt - eb, 32'd3);
    chk("s1_beat0_data", {16'd0, beat_log[lb].data}, 32'h0100);
    chk("s1_beat9_data", {16'd0, beat_log[lb+9].data}, 32'h1312);
    chk("s1_beat8_lbn", {31'd0, beat_log[lb+8].lbn}, 32'd1);
    chk("s1_beat8_lbn_len", {28'd0, beat_log[lb+8].lbn_len}, 32'd4);
    chk("s1_last_flag", {31'd0, beat_log[lb+10].last}, 32'd1);
    chk("s1_last_len", {30'd0, beat_log[lb+10].len}, 32'd0);
    cnt = 0;
    for (int i = lb; i < beat_log.size(); i++) cnt += int'(beat_log[i].lbn);
    chk("s1_lbn_count", cnt, 32'd1);
    chk("s1_done_pulses", done_cnt - db, 32'd1);
    chk("s1_sent", {16'd0, pkt_sent_cnt_o}, 32'd1);

    // Short packet.
    ready_rand = 1'b1;
    lb = beat_log.size();
    start_burst(16'd5, 16'd1, 8'd0);
    wait_idle(200);
    chk("s2_beats", beat_log.size() - lb, 32'd3);
    chk("s2_beat0_data", {16'd0, beat_log[lb].data}, 32'h0100);
    chk("s2_beat0_lbn", {31'd0, beat_log[lb].lbn}, 32'd1);
    chk("s2_beat0_lbn_len", {28'd0, beat_log[lb].lbn_len}, 32'd5);
    chk("s2_beat1_data", {16'd0, beat_log[lb+1].data}, 32'h0302);
    chk("s2_last_len", {30'd0, beat_log[lb+2].len}, 32'd1);
    chk("s2_last_data", {16'd0, beat_log[lb+2].data}, 32'h0004);

    // Sub-beat packet.
    lb = beat_log.size();
    start_burst(16'd1, 16'd1, 8'd0);
    wait_idle(200);
    chk("s3_beats", beat_log.size() - lb, 32'd1);
    chk("s3_last", {31'd0, beat_log[lb].last}, 32'd1);
    chk("s3_len", {30'd0, beat_log[lb].len}, 32'd1);
    chk("s3_data", {16'd0, beat_log[lb].data}, 32'h0000);
    chk("s3_lbn", {31'd0, beat_log[lb].lbn}, 32'd0);

    // Burst with gap; a second start while busy must be ignored.
    lb = beat_log.size();  db = done_cnt;
    start_burst(16'd4, 16'd3, 8'd2);
    repeat (3) @(posedge clk);
    #1;
    plen = 16'd9;  pcnt = 16'd1;  gap = 8'd0;  start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(500);
    chk("s4_beats", beat_log.size() - lb, 32'd9);
    chk("s4_pkt0_first", {24'd0, beat_log[lb].data[7:0]}, 32'h00);
    chk("s4_pkt1_first", {24'd0, beat_log[lb+3].data[7:0]}, 32'h01);
    chk("s4_pkt2_first", {24'd0, beat_log[lb+6].data[7:0]}, 32'h02);
    chk("s4_sent", {16'd0, pkt_sent_cnt_o}, 32'd3);
    chk("s4_gap_cycles", gap_seen, 32'd2);
    chk("s4_done_pulses", done_cnt - db, 32'd1);

    // Reset during DATA beat 3.
    ready_rand = 1'b0;
    ready_man = 1'b1;
    start_burst(16'd20, 16'd1, 8'd0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (app_len_o == 2'd2 && app_data_o == 16'h0706) found = 1'b1;
    end
    chk("s5_reached_beat3", {31'd0, found}, 32'd1);
    nreset = 1'b1;
    @(negedge clk);
    chk("s5_busy", {31'd0, busy_o}, 32'd0);
    chk("s5_data", {16'd0, app_data_o}, 32'd0);
    chk("s5_sent", {16'd0, pkt_sent_cnt_o}, 32'd0);
    chk("s5_early", {31'd0, app_early_v_o}, 32'd0);
    @(posedge clk);
    #1 nreset = 1'b0;
    lb = beat_log.size();
    start_burst(16'd4, 16'd1, 8'd0);
    wait_idle(200);
    chk("s5_restart_data", {16'd0, beat_log[lb].data}, 32'h0100);
    chk("s5_restart_sent", {16'd0, pkt_sent_cnt_o}, 32'd1);
    ready_man = 1'b0;

`ifdef ETH_TX_PKT_GEN_CANCEL_EN
    // Cancel on beat 2 of each packet.
    ready_rand = 1'b1;
    cancel_en = 1'b1;
    cancel_beat = 16'd2;
    lb = beat_log.size();  db = done_cnt;
    start_burst(16'd20, 16'd2, 8'd0);
    wait_idle(500);
    chk("s6_beats", beat_log.size() - lb, 32'd6);
    chk("s6_cancel_p0", {31'd0, beat_log[lb+2].cancel}, 32'd1);
    chk("s6_cancel_p1", {31'd0, beat_log[lb+5].cancel}, 32'd1);
    cnt = 0;
    for (int i = lb; i < beat_log.size(); i++) cnt += int'(beat_log[i].last);
    chk("s6_no_last", cnt, 32'd0);
    chk("s6_sent", {16'd0, pkt_sent_cnt_o}, 32'd2);
    chk("s6_done_pulses", done_cnt - db, 32'd1);
    cancel_en = 1'b0;
`endif

    // Randomized bursts against the model.
    ready_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      cancel_en = 1'($urandom_range(0, 1));
      cancel_beat = 16'($urandom_range(0, 20));
      start_burst(16'($urandom_range(1, 40)), 16'($urandom_range(1, 3)),
                  8'($urandom_range(0, 3)));
      wait_idle(2000);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
